// File: rtl/ps2_host_if.sv
// Host-side byte streams of the PS/2 host: command bytes out, received bytes in.
// The master modport is the system side; the slave modport is ps2_host itself.
interface ps2_host_if;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       tx_done;
   logic       tx_error;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_error;
   logic       rx_overflow;

   modport master (
      output tx_valid, tx_data, rx_ready,
      input  tx_ready, tx_done, tx_error, rx_valid, rx_data, rx_error, rx_overflow
   );

   modport slave (
      input  tx_valid, tx_data, rx_ready,
      output tx_ready, tx_done, tx_error, rx_valid, rx_data, rx_error, rx_overflow
   );
endinterface

// File: rtl/ps2_host.sv
// PS/2 host: filtered clock, 11-bit frame receiver with FIFO, and the
// inhibit/request-to-send transmitter with device acknowledge and frame timeout.
//
// state        | meaning
// S_IDLE       | lines released, waiting for a device fall or a host byte
// S_RX         | shifting in start, D0-D7, parity, stop on device falls
// S_TX_INHIBIT | clock held low to abort device activity
// S_TX_REQ     | data pulled low (start bit) while clock still held
// S_TX_DATA    | clock released, data/parity/stop driven on device falls
// S_TX_ACK     | waiting for the device acknowledge fall
// S_TX_END     | waiting for the clock to return high before reporting
module ps2_host #(
   parameter int CLK_HZ     = 12000000,
   parameter int FIFO_DEPTH = 4,
   parameter int FILTER_LEN = 5,
   parameter int TIMEOUT_US = 2000
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     i_ps2_clk_in,
   input  logic     i_ps2_data_in,
   output logic     o_ps2_clk_oe,
   output logic     o_ps2_data_oe,
   ps2_host_if.slave bus
);
   localparam int     INH_CYC = CLK_HZ / 10000;
   localparam int     REQ_CYC = CLK_HZ / 50000;
   localparam longint TO_L    = longint'(TIMEOUT_US) * longint'(CLK_HZ) / 64'd1000000;
   localparam int     TO_CYC  = int'(TO_L);
   localparam int     TOW     = $clog2(TO_CYC + 1);
   localparam int     TW      = $clog2(INH_CYC + 1);
   localparam int     FW      = $clog2(FILTER_LEN + 1);
   localparam int     AW      = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_RX, S_TX_INHIBIT, S_TX_REQ, S_TX_DATA, S_TX_ACK, S_TX_END
   } state_t;

   state_t          r_state, w_next;
   logic            r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
   logic            r_filt, r_filt_q;
   logic [FW-1:0]   r_filt_cnt;
   logic [TW-1:0]   r_tmr;
   logic [TOW-1:0]  r_to_cnt;
   logic [3:0]      r_bit_cnt;
   logic [10:0]     r_rx_sr;
   logic [7:0]      r_tx_byte;
   logic            r_tx_par, r_tx_oe, r_ack;
   logic            r_tx_done, r_tx_err, r_rx_err, r_rx_ovf;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW:0]     r_wr, r_rd;

   logic w_fall, w_tx_ready, w_accept, w_timed, w_timeout, w_rx_done, w_frame_ok;
   logic w_tx_bit, w_empty, w_full, w_pop, w_push;

   assign w_fall     = r_filt_q & ~r_filt;
   assign w_accept   = w_tx_ready & bus.tx_valid;
   assign w_timed    = (r_state == S_RX) || (r_state == S_TX_DATA) || (r_state == S_TX_ACK);
   assign w_timeout  = w_timed && !w_fall && (r_to_cnt == TOW'(TO_CYC - 1));
   assign w_rx_done  = (r_state == S_RX) && (r_bit_cnt == 4'd11);
   assign w_frame_ok = !r_rx_sr[0] && r_rx_sr[10] && (^r_rx_sr[9:1]);
   assign w_tx_bit   = (r_bit_cnt < 4'd8)  ? r_tx_byte[r_bit_cnt[2:0]] :
                       (r_bit_cnt == 4'd8) ? r_tx_par : 1'b1;

   // Clock needs FILTER_LEN consecutive disagreeing samples before it moves.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_clk_s1   <= 1'b1;
         r_clk_s2   <= 1'b1;
         r_dat_s1   <= 1'b1;
         r_dat_s2   <= 1'b1;
         r_filt     <= 1'b1;
         r_filt_q   <= 1'b1;
         r_filt_cnt <= '0;
      end else begin
         r_clk_s1 <= i_ps2_clk_in;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= i_ps2_data_in;
         r_dat_s2 <= r_dat_s1;
         r_filt_q <= r_filt;
         if (r_clk_s2 == r_filt) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
            r_filt     <= r_clk_s2;
            r_filt_cnt <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:       if (w_fall) w_next = S_RX;
                       else if (w_accept) w_next = S_TX_INHIBIT;
         S_RX:         if (w_rx_done || w_timeout) w_next = S_IDLE;
         S_TX_INHIBIT: if (r_tmr == '0) w_next = S_TX_REQ;
         S_TX_REQ:     if (r_tmr == '0) w_next = S_TX_DATA;
         S_TX_DATA:    if (w_timeout) w_next = S_IDLE;
                       else if (w_fall && r_bit_cnt == 4'd9) w_next = S_TX_ACK;
         S_TX_ACK:     if (w_timeout) w_next = S_IDLE;
                       else if (w_fall) w_next = S_TX_END;
         S_TX_END:     if (r_filt) w_next = S_IDLE;
         default:      w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_ps2_clk_oe  = (r_state == S_TX_INHIBIT) || (r_state == S_TX_REQ);
      o_ps2_data_oe = (r_state == S_TX_REQ) ||
                      (((r_state == S_TX_DATA) || (r_state == S_TX_ACK)) && r_tx_oe);
      w_tx_ready    = (r_state == S_IDLE) && r_filt && !w_fall && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tmr     <= '0;
         r_to_cnt  <= '0;
         r_bit_cnt <= '0;
         r_rx_sr   <= '0;
         r_tx_byte <= '0;
         r_tx_par  <= 1'b0;
         r_tx_oe   <= 1'b0;
         r_ack     <= 1'b0;
         r_tx_done <= 1'b0;
         r_tx_err  <= 1'b0;
         r_rx_err  <= 1'b0;
      end else begin
         r_tx_done <= 1'b0;
         r_tx_err  <= 1'b0;
         r_rx_err  <= 1'b0;
         r_to_cnt  <= (!w_timed || w_fall) ? '0 : r_to_cnt + TOW'(1);

         if (w_accept && !w_fall) begin
            r_tmr     <= TW'(INH_CYC - 1);
            r_tx_byte <= bus.tx_data;
            r_tx_par  <= ~^bus.tx_data;
            r_tx_oe   <= 1'b1;
            r_bit_cnt <= '0;
         end else if (r_state == S_TX_INHIBIT) begin
            r_tmr <= (r_tmr == '0) ? TW'(REQ_CYC - 1) : r_tmr - TW'(1);
         end else if (r_state == S_TX_REQ && r_tmr != '0) begin
            r_tmr <= r_tmr - TW'(1);
         end

         if ((r_state == S_IDLE || r_state == S_RX) && w_fall) begin
            r_rx_sr   <= {r_dat_s2, r_rx_sr[10:1]};
            r_bit_cnt <= (r_state == S_IDLE) ? 4'd1 : r_bit_cnt + 4'd1;
         end
         if (w_rx_done && !w_frame_ok) r_rx_err <= 1'b1;

         if (r_state == S_TX_DATA && w_fall) begin
            r_tx_oe   <= ~w_tx_bit;
            r_bit_cnt <= r_bit_cnt + 4'd1;
         end
         if (r_state == S_TX_ACK && w_fall) r_ack <= ~r_dat_s2;
         if (r_state == S_TX_END && r_filt) begin
            r_tx_done <= r_ack;
            r_tx_err  <= ~r_ack;
         end

         if (w_timeout) begin
            r_rx_err <= (r_state == S_RX);
            r_tx_err <= (r_state != S_RX);
         end
      end
   end

   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop   = !w_empty && bus.rx_ready;
   // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
   assign w_push  = w_rx_done && w_frame_ok && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr[AW-1:0]] <= r_rx_sr[8:1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr     <= '0;
         r_rd     <= '0;
         r_rx_ovf <= 1'b0;
      end else begin
         r_rx_ovf <= w_rx_done && w_frame_ok && w_full && !w_pop;
         if (w_push) r_wr <= r_wr + (AW+1)'(1);
         if (w_pop)  r_rd <= r_rd + (AW+1)'(1);
      end
   end

   assign bus.tx_ready    = w_tx_ready;
   assign bus.tx_done     = r_tx_done;
   assign bus.tx_error    = r_tx_err;
   assign bus.rx_valid    = !w_empty;
   assign bus.rx_data     = w_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
   assign bus.rx_error    = r_rx_err;
   assign bus.rx_overflow = r_rx_ovf;
endmodule

// File: tb/tb_ps2_host.sv
// Directed bench for ps2_host: a PS/2 device model on open-drain pins, receive
// frames, FIFO overflow, host transmit with/without ack, timeout, contention, reset.
module tb_ps2_host;
   logic clk = 1'b0;
   logic reset;
   logic dev_clk = 1'b1;
   logic dev_data = 1'b1;
   logic clk_oe, data_oe;
   logic w_ps2_clk, w_ps2_data;

   int n_tests = 0;
   int n_fail  = 0;
   int n_rxerr = 0, n_ovf = 0, n_done = 0, n_txerr = 0, n_clkoe = 0;

   ps2_host_if bus();

   assign w_ps2_clk  = dev_clk  & ~clk_oe;
   assign w_ps2_data = dev_data & ~data_oe;

   ps2_host dut (
      .clk           (clk),
      .reset         (reset),
      .i_ps2_clk_in  (w_ps2_clk),
      .i_ps2_data_in (w_ps2_data),
      .o_ps2_clk_oe  (clk_oe),
      .o_ps2_data_oe (data_oe),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.rx_error)    n_rxerr++;
      if (bus.rx_overflow) n_ovf++;
      if (bus.tx_done)     n_done++;
      if (bus.tx_error)    n_txerr++;
      if (clk_oe)          n_clkoe++;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input int half, input int nbits);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_data = f[i];
         wait_cyc(half);
         dev_clk = 1'b0;
         wait_cyc(half);
         dev_clk = 1'b1;
      end
      dev_data = 1'b1;
   endtask

   task automatic pop_one();
      bus.rx_ready = 1'b1;
      @(negedge clk);
      bus.rx_ready = 1'b0;
   endtask

   // mode 0: device acks, 1: device does not ack, 2: device silent
   task automatic do_tx(input logic [7:0] b, input int mode, input string tag);
      int kd, kc, k, half, e_done, e_err;
      bit seen;
      logic [9:0] bits;
      half   = 100;
      kd     = -1;
      kc     = -1;
      e_done = n_done;
      e_err  = n_txerr;
      seen   = 0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         seen = bus.tx_ready;
      end
      chk({tag, "_ready"}, 32'(seen), 32'd1);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      for (k = 0; k < 3000; k++) begin
         @(negedge clk);
         bus.tx_valid = 1'b0;
         if (data_oe && kd < 0) kd = k;
         if (!clk_oe) begin
            kc = k;
            break;
         end
      end
      chk({tag, "_inhibit_len"}, 32'(kd), 32'd1200);
      chk({tag, "_release_at"},  32'(kc), 32'd1440);
      if (mode == 2) begin
         for (k = 1; k <= 30000; k++) begin
            @(negedge clk);
            if (bus.tx_error) break;
         end
         chk({tag, "_timeout_cyc"}, 32'(k), 32'd24000);
      end else begin
         bits = '0;
         for (int n = 0; n < 10; n++) begin
            wait_cyc(half);
            dev_clk = 1'b0;
            wait_cyc(half);
            dev_clk = 1'b1;
            bits[n] = w_ps2_data;
         end
         dev_data = (mode == 0) ? 1'b0 : 1'b1;
         wait_cyc(half);
         dev_clk = 1'b0;
         wait_cyc(half);
         dev_clk  = 1'b1;
         dev_data = 1'b1;
         wait_cyc(30);
         chk({tag, "_bits"}, 32'(bits), {22'd0, 1'b1, ~^b, b});
      end
      wait_cyc(5);
      chk({tag, "_done_cnt"}, 32'(n_done - e_done), (mode == 0) ? 32'd1 : 32'd0);
      chk({tag, "_err_cnt"},  32'(n_txerr - e_err), (mode == 0) ? 32'd0 : 32'd1);
      chk({tag, "_oe_idle"},  {30'd0, clk_oe, data_oe}, 32'd0);
   endtask

   initial begin
      int e0, e1, ce;
      bit found;
      reset        = 1'b1;
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'h00;
      bus.rx_ready = 1'b0;
      wait_cyc(3);
      chk("rst_oe",       {30'd0, clk_oe, data_oe}, 32'd0);
      chk("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst_rx_data",  32'(bus.rx_data), 32'd0);
      chk("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
      chk("rst_pulses",   {28'd0, bus.tx_done, bus.tx_error, bus.rx_error, bus.rx_overflow}, 32'd0);
      reset = 1'b0;
      wait_cyc(2);
      chk("idle_tx_ready", 32'(bus.tx_ready), 32'd1);

      // good frame at 12.5 kHz
      e0 = n_rxerr;
      send_frame(8'h1C, 0, 480, 11);
      chk("rx1c_valid", 32'(bus.rx_valid), 32'd1);
      chk("rx1c_data",  32'(bus.rx_data), 32'h1C);
      chk("rx1c_noerr", 32'(n_rxerr - e0), 32'd0);
      pop_one();
      chk("rx1c_popped", 32'(bus.rx_valid), 32'd0);

      // bad parity
      e0 = n_rxerr;
      send_frame(8'h1C, 1, 100, 11);
      wait_cyc(20);
      chk("par_err_cnt", 32'(n_rxerr - e0), 32'd1);
      chk("par_empty",   32'(bus.rx_valid), 32'd0);

      // overflow
      e1 = n_ovf;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 0, 100, 11);
         wait_cyc(10);
         if (i == 4) chk("ovf_after4", 32'(n_ovf - e1), 32'd0);
      end
      chk("ovf_after5", 32'(n_ovf - e1), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("ovf_pop%0d", i), 32'(bus.rx_data), 32'(i));
         pop_one();
      end
      chk("ovf_empty", 32'(bus.rx_valid), 32'd0);

      do_tx(8'hED, 0, "tx_ack");
      do_tx(8'hED, 1, "tx_nak");
      do_tx(8'h5A, 2, "tx_silent");

      // device fall coincides with an offered command byte
      ce    = n_clkoe;
      found = 0;
      bus.tx_data = 8'h55;
      fork
         send_frame(8'hA5, 0, 100, 11);
         begin
            for (int i = 0; i < 400 && !found; i++) begin
               @(negedge clk);
               found = !bus.tx_ready;
            end
            bus.tx_valid = 1'b1;
            @(negedge clk);
            chk("cont_ready_low", 32'(bus.tx_ready), 32'd0);
            wait_cyc(300);
            bus.tx_valid = 1'b0;
         end
      join
      wait_cyc(20);
      chk("cont_fall_seen", 32'(found), 32'd1);
      chk("cont_no_tx",     32'(n_clkoe - ce), 32'd0);
      chk("cont_rx_data",   32'(bus.rx_data), 32'hA5);

      // reset in the middle of a received frame; A5 is still queued
      e0 = n_rxerr + n_ovf + n_done + n_txerr;
      send_frame(8'h3C, 0, 100, 6);
      reset = 1'b1;
      wait_cyc(2);
      chk("mid_rst_oe",  {30'd0, clk_oe, data_oe}, 32'd0);
      reset = 1'b0;
      wait_cyc(400);
      chk("mid_rst_empty",  32'(bus.rx_valid), 32'd0);
      chk("mid_rst_data",   32'(bus.rx_data), 32'd0);
      chk("mid_rst_pulses", 32'(n_rxerr + n_ovf + n_done + n_txerr - e0), 32'd0);
      chk("mid_rst_ready",  32'(bus.tx_ready), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
